// File: rtl/counter.sv
// Purpose : loadable WIDTH-bit up-counter with synchronous reset; priority rst > load > inc > hold.
// Latency : 1 cycle; every action is visible on cnt after the rising edge that samples it.
// Backpressure: none; every input is acted on in the cycle it is sampled.
//
// Ports:
//   clk  - sole clock; all state updates on the rising edge
//   rst  - synchronous active-high reset; loads RESET_VAL
//   inc  - increment enable, level-sensitive (each enabled edge counts once)
//   load - parallel-load enable; takes priority over inc
//   din  - parallel-load data [WIDTH-1:0]
//   cnt  - current count [WIDTH-1:0], driven directly from r_cnt
//
// Build option: define COUNTER_SATURATE_EN to make an increment at the
// all-ones value hold there instead of wrapping to zero.
module counter #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] cnt
);

  // RESET_VAL may be wider than the counter; only the low WIDTH bits are kept.
  localparam logic [WIDTH-1:0] LP_RESET_VAL = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] LP_ONE       = WIDTH'(1);

  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] w_cnt_inc;
  logic [WIDTH-1:0] w_cnt_nxt;

`ifdef COUNTER_SATURATE_EN
  // Stick at all-ones rather than rolling over.
  assign w_cnt_inc = (r_cnt == '1) ? r_cnt : (r_cnt + LP_ONE);
`else
  // Natural modulo-2^WIDTH rollover.
  assign w_cnt_inc = r_cnt + LP_ONE;
`endif

  // Load beats increment; reset is handled in the register process so it
  // overrides everything regardless of the other inputs.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (load) begin
      w_cnt_nxt = din;
    end else if (inc) begin
      w_cnt_nxt = w_cnt_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= LP_RESET_VAL;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end

  assign cnt = r_cnt;

endmodule

// File: tb/tb_counter.sv
// Purpose : directed self-checking bench for counter (WIDTH=8, RESET_VAL=0).
// Latency : results are sampled 1 time unit after each rising edge.
// Backpressure: not applicable; stimulus is a fixed linear sequence.
module tb_counter;

  logic       clk;
  logic       rst;
  logic       inc;
  logic       load;
  logic [7:0] din;
  logic [7:0] cnt;

  int total;
  int bad;

  counter #(
    .WIDTH     (8),
    .RESET_VAL (0)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .inc  (inc),
    .load (load),
    .din  (din),
    .cnt  (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] exp);
    total++;
    assert (cnt === exp) else begin
      bad++;
      $error("FAIL %s: cnt=0x%02h expected=0x%02h", tag, cnt, exp);
    end
  endtask

  // Advance one rising edge and land 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    inc   = 1'b0;
    load  = 1'b0;
    din   = 8'h00;

    // Reset for 10 cycles.
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("reset_hold", 8'h00);
    end

    // 10 single-cycle inc pulses, each followed by 6 idle cycles.
    rst = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      inc = 1'b1;
      tick();
      inc = 1'b0;
      chk("inc_pulse", 8'(i));
      for (int j = 0; j < 6; j++) begin
        tick();
        chk("idle_hold", 8'(i));
      end
    end
    chk("after_10_pulses", 8'h0A);

    // Load 0x5A, then 10 inc pulses -> 0x64.
    load = 1'b1;
    din  = 8'h5A;
    tick();
    load = 1'b0;
    din  = 8'h00;
    chk("load_5a", 8'h5A);
    for (int i = 0; i < 10; i++) begin
      inc = 1'b1;
      tick();
      inc = 1'b0;
      tick();
    end
    chk("load_then_10_inc", 8'h64);

    // Reset held while inc pulses (and one load) are applied.
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      inc = 1'b1;
      tick();
      inc = 1'b0;
      chk("inc_during_reset", 8'h00);
      tick();
      chk("idle_during_reset", 8'h00);
    end
    load = 1'b1;
    din  = 8'hC3;
    tick();
    load = 1'b0;
    chk("load_during_reset", 8'h00);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      inc = 1'b1;
      tick();
      inc = 1'b0;
    end
    chk("inc_after_reset", 8'h0A);

    // load and inc together: load wins.
    load = 1'b1;
    inc  = 1'b1;
    din  = 8'h33;
    tick();
    load = 1'b0;
    inc  = 1'b0;
    chk("load_beats_inc", 8'h33);

    // rst and load together: reset wins.
    rst  = 1'b1;
    load = 1'b1;
    din  = 8'h77;
    tick();
    rst  = 1'b0;
    load = 1'b0;
    chk("rst_beats_load", 8'h00);

    // Reset raised between edges must not act until the next edge.
    load = 1'b1;
    din  = 8'h44;
    tick();
    load = 1'b0;
    chk("load_44", 8'h44);
    rst = 1'b1;
    #3;
    chk("rst_between_edges", 8'h44);
    tick();
    rst = 1'b0;
    chk("rst_at_edge", 8'h00);

    // Top-of-range behaviour.
    load = 1'b1;
    din  = 8'hFF;
    tick();
    load = 1'b0;
    chk("load_ff", 8'hFF);
    inc = 1'b1;
    tick();
    inc = 1'b0;
`ifdef COUNTER_SATURATE_EN
    chk("inc_at_max", 8'hFF);
    inc = 1'b1;
    tick();
    inc = 1'b0;
    chk("inc_at_max_again", 8'hFF);
`else
    chk("inc_at_max", 8'h00);
    inc = 1'b1;
    tick();
    inc = 1'b0;
    chk("inc_after_wrap", 8'h01);
`endif

    // inc held high for 5 consecutive edges from 0x00.
    load = 1'b1;
    din  = 8'h00;
    tick();
    load = 1'b0;
    chk("load_00", 8'h00);
    inc = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("inc_held", 8'(i));
    end
    inc = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_after_held_inc", 8'h05);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
